// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - EX-stage operand forwarding, load-use hazard and freeze-hold unit
//
// Purpose:
//   Resolves NUM_SRC EX-stage source operands against NUM_FWD downstream stages
//   (stage 0 = youngest, highest priority). Raises a load-use stall when an operand's
//   winning producer is a load whose data is not yet final. Operands that are already
//   resolved are latched while the pipeline is externally frozen, so the ALU inputs stay
//   steady even if the downstream stages change underneath a cache-miss freeze.
//
// Ports:
//   clk, rst        clock; synchronous reset, active-low
//   ex_valid        EX holds a real instruction
//   src_idx         packed source register indices (src 0 in the LSBs)
//   src_used        per-source read enable
//   src_rf_data     packed register-file values from ID/EX
//   fwd_ld_rf       per-stage regfile write enable
//   fwd_dest        packed per-stage destination register
//   fwd_data        packed per-stage result
//   fwd_is_load     per-stage load flag
//   fwd_data_ok     per-stage data-final flag
//   pipe_stall      external freeze
//   src_out         packed resolved operands
//   src_sel         packed operand source select (0 = regfile, k+1 = stage k)
//   lu_stall        load-use stall request
//   fwd_cnt         cycles in which any operand was forwarded
//   lu_stall_cnt    load-use stall cycles

module fwd_hazard_unit #(
  parameter int XLEN    = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int NUM_FWD = 2,
  parameter int CNT_W   = 32,
  localparam int SELW   = $clog2(NUM_FWD + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ex_valid,
  input  logic [NUM_SRC*REG_AW-1:0] src_idx,
  input  logic [NUM_SRC-1:0]        src_used,
  input  logic [NUM_SRC*XLEN-1:0]   src_rf_data,
  input  logic [NUM_FWD-1:0]        fwd_ld_rf,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_dest,
  input  logic [NUM_FWD*XLEN-1:0]   fwd_data,
  input  logic [NUM_FWD-1:0]        fwd_is_load,
  input  logic [NUM_FWD-1:0]        fwd_data_ok,
  input  logic                      pipe_stall,
  output logic [NUM_SRC*XLEN-1:0]   src_out,
  output logic [NUM_SRC*SELW-1:0]   src_sel,
  output logic                      lu_stall,
  output logic [CNT_W-1:0]          fwd_cnt,
  output logic [CNT_W-1:0]          lu_stall_cnt
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LU_WAIT = 2'd1,
    ST_HOLD    = 2'd2
  } state_e;

  state_e                       state_q, state_d;
  logic [NUM_SRC-1:0]           hold_v_q, hold_v_d;
  logic [NUM_SRC-1:0][XLEN-1:0] hold_val_q, hold_val_d;
  logic [NUM_SRC-1:0][SELW-1:0] hold_sel_q, hold_sel_d;
  logic [CNT_W-1:0]             fwd_cnt_q, fwd_cnt_d;
  logic [CNT_W-1:0]             lu_stall_cnt_q, lu_stall_cnt_d;

  logic [NUM_SRC-1:0][XLEN-1:0] live_val;
  logic [NUM_SRC-1:0][SELW-1:0] live_sel;
  logic [NUM_SRC-1:0]           src_hz;
  logic [NUM_SRC-1:0]           capture;
  logic                         hz_all;
  logic                         hz_open;
  logic                         any_fwd;

  // Live resolution. Stages are scanned oldest to youngest so the youngest match
  // overwrites the rest; an unready winning load masks every older stage.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      live_val[i] = src_rf_data[i*XLEN +: XLEN];
      live_sel[i] = '0;
      src_hz[i]   = 1'b0;
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
        if (src_used[i] && fwd_ld_rf[k] &&
            (fwd_dest[k*REG_AW +: REG_AW] == src_idx[i*REG_AW +: REG_AW]) &&
            (src_idx[i*REG_AW +: REG_AW] != '0)) begin
          if (!fwd_is_load[k] || fwd_data_ok[k]) begin
            live_val[i] = fwd_data[k*XLEN +: XLEN];
            live_sel[i] = SELW'(k + 1);
            src_hz[i]   = 1'b0;
          end else begin
            live_val[i] = src_rf_data[i*XLEN +: XLEN];
            live_sel[i] = '0;
            src_hz[i]   = 1'b1;
          end
        end
      end
    end
  end

  assign hz_all  = ex_valid & (|src_hz);
  // During a freeze only sources not yet latched can still cause a stall.
  assign hz_open = ex_valid & (|(src_hz & ~hold_v_q));

  // Next-state, stall request and hold capture.
  always_comb begin
    state_d    = state_q;
    hold_v_d   = hold_v_q;
    hold_val_d = hold_val_q;
    hold_sel_d = hold_sel_q;
    lu_stall   = 1'b0;
    capture    = '0;

    case (state_q)
      ST_RUN: begin
        lu_stall = hz_all;
        // A freeze wins over a hazard: the hazarded source simply stays live in HOLD.
        if (pipe_stall) begin
          state_d = ST_HOLD;
          capture = ~src_hz;
        end else if (hz_all) begin
          state_d = ST_LU_WAIT;
        end
      end
      ST_LU_WAIT: begin
        lu_stall = hz_all;
        if (!hz_all) begin
          if (pipe_stall) begin
            state_d = ST_HOLD;
            capture = ~src_hz;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_HOLD: begin
        lu_stall = hz_open;
        if (!pipe_stall) begin
          state_d  = ST_RUN;
          hold_v_d = '0;
        end else begin
          capture = ~src_hz & ~hold_v_q;
        end
      end
      default: begin
        state_d  = ST_RUN;
        hold_v_d = '0;
      end
    endcase

    for (int i = 0; i < NUM_SRC; i++) begin
      if (capture[i]) begin
        hold_v_d[i]   = 1'b1;
        hold_val_d[i] = live_val[i];
        hold_sel_d[i] = live_sel[i];
      end
    end
  end

  // Operand output mux: latched values take over only inside a freeze.
  always_comb begin
    src_out = '0;
    src_sel = '0;
    any_fwd = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if ((state_q == ST_HOLD) && hold_v_q[i]) begin
        src_out[i*XLEN +: XLEN] = hold_val_q[i];
        src_sel[i*SELW +: SELW] = hold_sel_q[i];
      end else begin
        src_out[i*XLEN +: XLEN] = live_val[i];
        src_sel[i*SELW +: SELW] = live_sel[i];
      end
      any_fwd = any_fwd | (src_sel[i*SELW +: SELW] != '0);
    end
  end

  // Performance counters; wrap naturally at 2^CNT_W.
  always_comb begin
    fwd_cnt_d      = fwd_cnt_q;
    lu_stall_cnt_d = lu_stall_cnt_q;
    if (lu_stall && !pipe_stall) begin
      lu_stall_cnt_d = lu_stall_cnt_q + CNT_W'(1);
    end
    if (ex_valid && !lu_stall && !pipe_stall && any_fwd) begin
      fwd_cnt_d = fwd_cnt_q + CNT_W'(1);
    end
  end

  assign fwd_cnt      = fwd_cnt_q;
  assign lu_stall_cnt = lu_stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= ST_RUN;
      hold_v_q       <= '0;
      hold_val_q     <= '0;
      hold_sel_q     <= '0;
      fwd_cnt_q      <= '0;
      lu_stall_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      hold_v_q       <= hold_v_d;
      hold_val_q     <= hold_val_d;
      hold_sel_q     <= hold_sel_d;
      fwd_cnt_q      <= fwd_cnt_d;
      lu_stall_cnt_q <= lu_stall_cnt_d;
    end
  end

endmodule
